// File: rtl/data_ram_pkg.sv
// data_ram shared types: lane/word widths, drain state, store-buffer entry.
// DATA_RAM_FWD_EN selects store-to-load forwarding in the users of this package.
package data_ram_pkg;

  localparam int SEL_W  = 4;
  localparam int WORD_W = 32;
  localparam int WIDX_W = 30;

  typedef enum logic {IDLE, BUSY} drain_st_t;

  typedef struct packed {
    logic [WIDX_W-1:0] widx;
    logic [SEL_W-1:0]  sel;
    logic [WORD_W-1:0] data;
  } sb_entry_t;

  function automatic logic [WORD_W-1:0] lane_merge(
    input logic [WORD_W-1:0] base,
    input logic [WORD_W-1:0] upd,
    input logic [SEL_W-1:0]  lanes
  );
    lane_merge = base;
    for (int l = 0; l < SEL_W; l++)
      if (lanes[l]) lane_merge[8*l +: 8] = upd[8*l +: 8];
  endfunction

endpackage

// File: rtl/data_ram_store_buf.sv
// Store-buffer FIFO with per-entry word-index compare.
// DATA_RAM_FWD_EN adds the oldest-to-newest overlay and lane mask.
module store_buf
  import data_ram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  sb_entry_t         din,
  input  logic [WIDX_W-1:0] q_widx,
  output logic              full,
  output logic              empty,
  output logic              last,
  output sb_entry_t         head,
  output logic [DEPTH-1:0]  match
`ifdef DATA_RAM_FWD_EN
  ,
  output logic [WORD_W-1:0] fwd_data,
  output logic [SEL_W-1:0]  fwd_mask
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);

  sb_entry_t     ent [DEPTH];
  logic [PW-1:0] hptr;
  logic [PW-1:0] tptr;
  logic [PW:0]   cnt;
  logic [PW-1:0] off [DEPTH];

  assign full  = cnt == FULL_CNT;
  assign empty = cnt == '0;
  assign last  = cnt == ONE_CNT;
  assign head  = ent[hptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hptr <= '0;
      tptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (push) begin
        ent[tptr] <= din;
        tptr      <= tptr + PW'(1);
      end
      if (pop) hptr <= hptr + PW'(1);
      if (push && !pop) cnt <= cnt + ONE_CNT;
      else if (pop && !push) cnt <= cnt - ONE_CNT;
    end
  end

  // Slot i is live when its distance from the head is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      off[i]   = PW'(i) - hptr;
      match[i] = ({1'b0, off[i]} < cnt) && (ent[i].widx == q_widx);
    end
  end

`ifdef DATA_RAM_FWD_EN
  logic [PW-1:0] idx;

  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    idx      = hptr;
    for (int k = 0; k < DEPTH; k++) begin
      idx = hptr + PW'(k);
      if (match[idx]) begin
        fwd_data = lane_merge(fwd_data, ent[idx].data, ent[idx].sel);
        fwd_mask = fwd_mask | ent[idx].sel;
      end
    end
  end
`endif

endmodule

// File: rtl/data_ram.sv
// Data memory with posted stores and a multi-cycle drain engine.
// DATA_RAM_FWD_EN: forward buffered stores to loads instead of stalling.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int SB_DEPTH   = 4,
  parameter int WR_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stallreq_o
);

  localparam int CW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [CW-1:0] RLD = CW'(WR_LAT - 1);

  logic [WORD_W-1:0]     ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] widx;
  logic [ADDR_WIDTH-1:0] cidx;
  logic [WIDX_W-1:0]     q_widx;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  last;
  sb_entry_t             head;
  sb_entry_t             din;
  logic [SB_DEPTH-1:0]   match;
  drain_st_t             state;
  drain_st_t             state_n;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_n;
  logic [WORD_W-1:0]     rd;
  logic [WORD_W-1:0]     ld;
  logic                  unused_ok;

  assign widx   = addr[ADDR_WIDTH+1:2];
  assign q_widx = WIDX_W'(widx);
  assign cidx   = head.widx[ADDR_WIDTH-1:0];
  assign push   = ce & we & ~full;
  assign rd     = ram[widx];
  assign din    = '{widx: q_widx, sel: sel, data: data_i};

`ifdef DATA_RAM_FWD_EN
  logic [WORD_W-1:0] fwd_data;
  logic [SEL_W-1:0]  fwd_mask;
`endif

  store_buf #(.DEPTH(SB_DEPTH)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .din      (din),
    .q_widx   (q_widx),
    .full     (full),
    .empty    (empty),
    .last     (last),
    .head     (head),
    .match    (match)
`ifdef DATA_RAM_FWD_EN
    ,
    .fwd_data (fwd_data),
    .fwd_mask (fwd_mask)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // A push on the commit edge keeps the engine busy.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_n = BUSY;
          cnt_n   = RLD;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          pop   = 1'b1;
          cnt_n = RLD;
          if (last && !push) begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (pop)
      for (int l = 0; l < SEL_W; l++)
        if (head.sel[l]) ram[cidx][8*l +: 8] <= head.data[8*l +: 8];
  end

`ifdef DATA_RAM_FWD_EN
  assign ld         = lane_merge(rd, fwd_data, fwd_mask);
  assign stallreq_o = rst_n & ce & we & full;
  assign unused_ok  = ^{addr[1:0], addr[31:ADDR_WIDTH+2],
                        head.widx[WIDX_W-1:ADDR_WIDTH], match};
`else
  assign ld         = rd;
  assign stallreq_o = rst_n & ce & (we ? full : |match);
  assign unused_ok  = ^{addr[1:0], addr[31:ADDR_WIDTH+2],
                        head.widx[WIDX_W-1:ADDR_WIDTH]};
`endif

  assign data_o = (rst_n & ce & ~we) ? ld : '0;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram against a queue-based memory model.
// Builds with or without DATA_RAM_FWD_EN.
module tb_data_ram;
  import data_ram_pkg::*;

  localparam int AW  = 10;
  localparam int SBD = 4;
  localparam int WL  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        stallreq_o;

  always #5 clk = ~clk;

  data_ram #(.ADDR_WIDTH(AW), .SB_DEPTH(SBD), .WR_LAT(WL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .we         (we),
    .addr       (addr),
    .sel        (sel),
    .data_i     (data_i),
    .data_o     (data_o),
    .stallreq_o (stallreq_o)
  );

  typedef struct {
    int          w;
    logic [3:0]  s;
    logic [31:0] d;
  } st_t;

  st_t         q[$];
  logic [31:0] mref [int];
  int          remain = -1;
  int          n_chk = 0;
  int          n_fail = 0;
  int          stalls = 0;
  logic [31:0] last_do;
  logic        last_st;

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] s);
    for (int l = 0; l < 4; l++)
      if (s[l]) o[8*l +: 8] = n[8*l +: 8];
    return o;
  endfunction

  function automatic bit hit(input int wi);
    foreach (q[i]) if (q[i].w == wi) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit load_blocked(input int wi);
`ifdef DATA_RAM_FWD_EN
    return (wi < 0);
`else
    return hit(wi);
`endif
  endfunction

  function automatic logic [31:0] exp_load(input int wi);
    logic [31:0] v = mref[wi];
`ifdef DATA_RAM_FWD_EN
    foreach (q[i]) if (q[i].w == wi) v = merge(v, q[i].d, q[i].s);
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit push, input int wi,
                            input logic [3:0] s, input logic [31:0] d);
    bit commit = 1'b0;
    if (remain < 0) begin
      if (q.size() > 0) remain = WL;
    end else begin
      remain--;
      if (remain == 0) begin
        commit = 1'b1;
        mref[q[0].w] = merge(mref.exists(q[0].w) ? mref[q[0].w] : 32'hxxxxxxxx,
                             q[0].d, q[0].s);
        void'(q.pop_front());
      end
    end
    if (push) q.push_back('{wi, s, d});
    if (commit) remain = (q.size() > 0) ? WL : -1;
  endtask

  task automatic cyc(input logic c, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d);
    int   wi;
    bit   full;
    logic es;
    @(negedge clk);
    ce = c; we = w; addr = a; sel = s; data_i = d;
    #1;
    wi      = int'(a[AW+1:2]);
    full    = q.size() == SBD;
    es      = c && (w ? full : load_blocked(wi));
    last_do = data_o;
    last_st = stallreq_o;
    if (c && w && stallreq_o) stalls++;
    chk("stall", 32'(stallreq_o), 32'(es));
    if (!c) chk("idle_data", data_o, 32'h0);
    else if (!w && !es && mref.exists(wi)) chk("load", data_o, exp_load(wi));
    @(posedge clk);
    model_edge(c && w && !full, wi, s, d);
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    int n = 0;
    do begin
      cyc(1'b1, 1'b1, a, s, d);
      n++;
    end while (last_st && n < 20);
    if (last_st) chk("store_accept_timeout", 32'(last_st), 32'h0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || remain >= 0) && n < 100) begin
      cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      n++;
    end
    n_chk++;
    assert (n < 100) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed %0d cycles expected <100", n);
    end
  endtask

  function automatic logic [31:0] waddr(input int w);
    logic [31:0] a = $urandom();
    a[AW+1:2] = AW'(w);
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] old1;
    logic [31:0] old2;
    logic [31:0] old3;
    int          n;

    #3;
    ce = 1'b1; we = 1'b0; addr = 32'h10;
    #1;
    chk("rst_data", data_o, 32'h0);
    chk("rst_stall_ld", 32'(stallreq_o), 32'h0);
    we = 1'b1;
    #1;
    chk("rst_stall_st", 32'(stallreq_o), 32'h0);
    chk("rst_fsm", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    ce = 1'b0; we = 1'b0;
    rst_n = 1'b1;

    for (int w = 0; w < 16; w++) store(waddr(w), 4'hF, $urandom());
    drain();

    store(32'h10, 4'hF, 32'h11223344);
`ifdef DATA_RAM_FWD_EN
    cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    chk("fwd_data", last_do, 32'h11223344);
    chk("fwd_stall", 32'(last_st), 32'h0);
`else
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
      if (!last_st) break;
      n++;
    end
    chk("nofwd_stall_cycles", 32'(n), 32'd3);
    chk("nofwd_data", last_do, 32'h11223344);
`endif
    drain();

    store(32'h20, 4'hF, 32'hAABBCCDD);
    drain();
    store(32'h20, 4'h4, 32'h00EE0000);
    drain();
    cyc(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    chk("byte_merge", last_do, 32'hAAEECCDD);

    stalls = 0;
    for (int w = 0; w < 8; w++) store(waddr(w), 4'hF, $urandom());
    chk("full_stall_seen", 32'(stalls > 0), 32'h1);
    drain();
    for (int w = 0; w < 8; w++) cyc(1'b1, 1'b0, waddr(w), 4'h0, 32'h0);

    old1 = mref[1]; old2 = mref[2]; old3 = mref[3];
    cyc(1'b1, 1'b1, waddr(1), 4'hF, ~old1);
    cyc(1'b1, 1'b1, waddr(2), 4'hF, ~old2);
    cyc(1'b1, 1'b1, waddr(3), 4'hF, ~old3);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = waddr(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", 32'(stallreq_o), 32'h0);
    chk("midrst_data", data_o, 32'h0);
    chk("midrst_fsm", 32'(dut.state), 32'(IDLE));
    chk("midrst_cnt", 32'(dut.cnt), 32'h0);
    q.delete();
    remain = -1;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, waddr(1), 4'h0, 32'h0);
    chk("midrst_keep1", last_do, old1);
    cyc(1'b1, 1'b0, waddr(2), 4'h0, 32'h0);
    chk("midrst_keep2", last_do, old2);
    cyc(1'b1, 1'b0, waddr(3), 4'h0, 32'h0);
    chk("midrst_keep3", last_do, old3);

    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, waddr($urandom_range(0, 15)), 4'hF, $urandom());
    for (int w = 0; w < 16; w++) cyc(1'b1, 1'b0, waddr(w), 4'h0, 32'h0);

    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom()),
          waddr($urandom_range(0, 15)), 4'($urandom()), $urandom());
    drain();
    for (int w = 0; w < 16; w++) cyc(1'b1, 1'b0, waddr(w), 4'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
